// File: rtl/scan_bridge_pkg.sv
// Shared definitions for the scan-to-memory/register bridge.
//   state_t      : bridge transaction FSM states
//   REG_REGION   : region code selecting the control-register bus
//   STATUS_IDX   : register index served locally (sticky status)
//   ERR_DATA     : response word for error and timeout completions
//   STS_*        : bit positions inside the status word
package scan_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [2:0]  REG_REGION = 3'd7;
  localparam logic [3:0]  STATUS_IDX = 4'hF;
  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

  localparam int STS_FFT_DONE = 0;
  localparam int STS_ERR      = 1;
  localparam int STS_TIMEOUT  = 2;
  localparam int STS_OVERRUN  = 3;

endpackage

// File: rtl/scan_id_sync.sv
// Brings the asynchronous scan_id command-valid level into the clk domain
// and turns each rising edge into a single-cycle id_valid pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   scan_id   : asynchronous level from the scan domain
//   id_valid  : registered 1-cycle pulse per synchronized rising edge
module scan_id_sync (
  input  logic clk,
  input  logic rst,
  input  logic scan_id,
  output logic id_valid
);

  logic sync_1;
  logic sync_2;
  logic level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      level_d  <= 1'b0;
      id_valid <= 1'b0;
    end else begin
      sync_1   <= scan_id;
      sync_2   <= sync_1;
      level_d  <= sync_2;
      id_valid <= sync_2 & ~level_d;
    end
  end

endmodule

// File: rtl/scan_mem_reg_bridge.sv
// Bridges single scan-side accesses onto NUM_SRAM SRAM banks or a small
// control-register bus. One transaction at a time:
//   IDLE -> DECODE -> ISSUE -> WAIT -> RESP -> IDLE
// Handshake: a rising edge of scan_id (after synchronization) starts a
// transaction; static_ready drops when the request is taken and rises with
// static_rdata valid when it completes, both held until the next request.
// Targets see a 1-cycle ren/wen strobe and answer with a ready pulse; ready
// may come back in the strobe cycle itself.
// Ports:
//   static_*        : scan-side request / response
//   scan_id         : asynchronous command-valid level
//   sram_*          : shared addr/wdata, one-hot strobes, per-bank rdata/ready
//   reg_*           : control-register bus (index 0xF is served locally)
//   fft_done        : status input reflected in the status word
//   state_dbg       : current FSM state
module scan_mem_reg_bridge
  import scan_bridge_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int SRAM_AW  = 9,
  parameter int NUM_SRAM = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     static_wen,
  input  logic                     static_ren,
  input  logic [ADDR_W-1:0]        static_addr,
  input  logic [DATA_W-1:0]        static_wdata,
  output logic [DATA_W-1:0]        static_rdata,
  output logic                     static_ready,
  input  logic                     scan_id,
  output logic [NUM_SRAM-1:0]      sram_ren,
  output logic [NUM_SRAM-1:0]      sram_wen,
  output logic [SRAM_AW-1:0]       sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic [NUM_SRAM*DATA_W-1:0] sram_rdata,
  input  logic [NUM_SRAM-1:0]      sram_ready,
  output logic                     reg_ren,
  output logic                     reg_wen,
  output logic [3:0]               reg_addr,
  output logic [DATA_W-1:0]        reg_wdata,
  input  logic [DATA_W-1:0]        reg_rdata,
  input  logic                     reg_ready,
  input  logic                     fft_done,
  output state_t                   state_dbg
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  logic id_valid;

  scan_id_sync u_scan_id_sync (
    .clk      (clk),
    .rst      (rst),
    .scan_id  (scan_id),
    .id_valid (id_valid)
  );

  state_t              state;
  logic                wen_q, ren_q, auto_q;
  logic [2:0]          region_q;
  logic [SRAM_AW-1:0]  off_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          last_region;
  logic [SRAM_AW-1:0]  last_off;
  logic [2:0]          cur_region;
  logic                sts_err, sts_timeout, sts_overrun;
  logic [CNT_W-1:0]    wait_cnt;

  logic [2:0]          eff_region;
  logic [SRAM_AW-1:0]  eff_off;
  logic                legal, is_status;
  logic [NUM_SRAM-1:0] bank_sel;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;
  logic [DATA_W-1:0]   status_word;

  // Address bits between the region field and the auto-increment bit carry
  // no meaning for this bridge.
  logic addr_unused;
  assign addr_unused = ^static_addr[ADDR_W-2:SRAM_AW+3];

  assign state_dbg = state;

  // Effective address: auto-increment continues from the last legal access
  // and wraps inside that region (4-bit index for registers).
  always_comb begin
    eff_region = region_q;
    eff_off    = off_q;
    if (auto_q) begin
      eff_region = last_region;
      if (last_region == REG_REGION) begin
        eff_off = {last_off[SRAM_AW-1:4], last_off[3:0] + 4'd1};
      end else begin
        eff_off = last_off + 1'b1;
      end
    end
    legal     = ((eff_region == REG_REGION) || (int'(eff_region) < NUM_SRAM))
                && (wen_q != ren_q);
    is_status = (eff_region == REG_REGION) && (eff_off[3:0] == STATUS_IDX);
    bank_sel  = '0;
    for (int b = 0; b < NUM_SRAM; b++) begin
      if (eff_region == 3'(b)) bank_sel[b] = 1'b1;
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    if (cur_region == REG_REGION) begin
      sel_ready = reg_ready;
      sel_rdata = reg_rdata;
    end else begin
      for (int b = 0; b < NUM_SRAM; b++) begin
        if (cur_region == 3'(b)) begin
          sel_ready = sram_ready[b];
          sel_rdata = sram_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    status_word               = '0;
    status_word[STS_FFT_DONE] = fft_done;
    status_word[STS_ERR]      = sts_err;
    status_word[STS_TIMEOUT]  = sts_timeout;
    status_word[STS_OVERRUN]  = sts_overrun;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      auto_q       <= 1'b0;
      region_q     <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      last_region  <= '0;
      last_off     <= '0;
      cur_region   <= '0;
      sts_err      <= 1'b0;
      sts_timeout  <= 1'b0;
      sts_overrun  <= 1'b0;
      wait_cnt     <= '0;
      static_rdata <= '0;
      static_ready <= 1'b1;
      sram_ren     <= '0;
      sram_wen     <= '0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      reg_ren      <= 1'b0;
      reg_wen      <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
    end else begin
      // A new request while busy is discarded; a status clear later in this
      // block takes priority over this set.
      if (id_valid && (state != IDLE)) sts_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (id_valid) begin
            wen_q        <= static_wen;
            ren_q        <= static_ren;
            auto_q       <= static_addr[ADDR_W-1];
            region_q     <= static_addr[SRAM_AW+2:SRAM_AW];
            off_q        <= static_addr[SRAM_AW-1:0];
            wdata_q      <= static_wdata;
            static_ready <= 1'b0;
            state        <= DECODE;
          end
        end

        DECODE: begin
          cur_region <= eff_region;
          if (!legal) begin
            sts_err      <= 1'b1;
            static_rdata <= ERR_WORD;
            static_ready <= 1'b1;
            state        <= RESP;
          end else begin
            last_region <= eff_region;
            last_off    <= eff_off;
            if (is_status) begin
              static_rdata <= wen_q ? '0 : status_word;
              if (wen_q && wdata_q[0]) begin
                sts_err     <= 1'b0;
                sts_timeout <= 1'b0;
                sts_overrun <= 1'b0;
              end
              static_ready <= 1'b1;
              state        <= RESP;
            end else begin
              if (eff_region == REG_REGION) begin
                reg_ren   <= ren_q;
                reg_wen   <= wen_q;
                reg_addr  <= eff_off[3:0];
                reg_wdata <= wdata_q;
              end else begin
                sram_ren   <= ren_q ? bank_sel : '0;
                sram_wen   <= wen_q ? bank_sel : '0;
                sram_addr  <= eff_off;
                sram_wdata <= wdata_q;
              end
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          sram_ren <= '0;
          sram_wen <= '0;
          reg_ren  <= 1'b0;
          reg_wen  <= 1'b0;
          wait_cnt <= '0;
          if (sel_ready) begin
            static_rdata <= ren_q ? sel_rdata : '0;
            static_ready <= 1'b1;
            state        <= RESP;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (sel_ready) begin
            static_rdata <= ren_q ? sel_rdata : '0;
            static_ready <= 1'b1;
            state        <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            static_rdata <= ERR_WORD;
            sts_timeout  <= 1'b1;
            static_ready <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mem_reg_bridge.sv
module tb_scan_mem_reg_bridge;
  import scan_bridge_pkg::*;

  localparam logic [15:0] NONE = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        static_wen, static_ren;
  logic [19:0] static_addr;
  logic [31:0] static_wdata;
  logic [31:0] static_rdata;
  logic        static_ready;
  logic        scan_id;
  logic [1:0]  sram_ren, sram_wen;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic [1:0]  sram_ready;
  logic        reg_ren, reg_wen;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        fft_done;
  state_t      state_dbg;

  scan_mem_reg_bridge #(
    .ADDR_W(20), .DATA_W(32), .SRAM_AW(9), .NUM_SRAM(2), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst),
    .static_wen(static_wen), .static_ren(static_ren),
    .static_addr(static_addr), .static_wdata(static_wdata),
    .static_rdata(static_rdata), .static_ready(static_ready),
    .scan_id(scan_id),
    .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .reg_ren(reg_ren), .reg_wen(reg_wen),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .fft_done(fft_done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  int sram_lat = 0;
  int reg_lat = 0;
  logic hold_reg_low = 1'b0;

  // ---------------- target models ----------------
  logic [31:0] sram_mem [2][512];
  logic [31:0] reg_mem [16];
  logic        pend = 1'b0;
  logic        p_reg, p_wr;
  int          p_bank, cnt;
  logic [8:0]  p_addr;

  always @(negedge clk) begin
    sram_ready = '0;
    reg_ready  = 1'b0;
    if (reg_ren || reg_wen) begin
      pend = 1'b1; p_reg = 1'b1; p_wr = reg_wen; p_addr = {5'd0, reg_addr}; cnt = reg_lat;
      if (reg_wen) reg_mem[reg_addr] = reg_wdata;
    end else if (|sram_ren || |sram_wen) begin
      pend = 1'b1; p_reg = 1'b0; p_wr = |sram_wen; p_addr = sram_addr; cnt = sram_lat;
      for (int b = 0; b < 2; b++) if (sram_ren[b] | sram_wen[b]) p_bank = b;
      if (p_wr) sram_mem[p_bank][sram_addr] = sram_wdata;
    end
    if (rst) pend = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        pend = 1'b0;
        if (p_reg) begin
          if (!hold_reg_low) begin
            reg_ready = 1'b1;
            reg_rdata = p_wr ? 32'hFFFF_FFFF : reg_mem[p_addr[3:0]];
          end
        end else begin
          sram_ready[p_bank] = 1'b1;
          sram_rdata = '1;
          if (!p_wr) sram_rdata[p_bank*32 +: 32] = sram_mem[p_bank][p_addr];
        end
      end else begin
        cnt--;
      end
    end
  end

  // ---------------- strobe monitor ----------------
  // code = {multi, 0, is_reg, wr, bank[2:0], addr[8:0]}
  logic [15:0] obs_arr [128];
  int obs_cnt = 0;
  int rd_idx = 0;

  always @(negedge clk) begin
    logic [15:0] code;
    if (|sram_ren || |sram_wen || reg_ren || reg_wen) begin
      code = 16'h0;
      if (reg_ren || reg_wen) code = {3'b001, reg_wen, 3'd0, 5'd0, reg_addr};
      else begin
        for (int b = 0; b < 2; b++)
          if (sram_ren[b] | sram_wen[b]) code = {3'b000, |sram_wen, 3'(b), sram_addr};
      end
      code[15] = ($countones({sram_ren, sram_wen, reg_ren, reg_wen}) != 1);
      if (obs_cnt < 128) obs_arr[obs_cnt] = code;
      obs_cnt++;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [19:0] mk(input logic ab, input logic [2:0] rg, input logic [8:0] off);
    return {ab, 7'd0, rg, off};
  endfunction

  function automatic logic [15:0] sc(input logic is_reg, input logic wr, input logic [2:0] bank,
                                     input logic [8:0] a);
    return {2'b00, is_reg, wr, bank, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_strobes(input string name, input logic [15:0] exp);
    if (exp == NONE) begin
      chk({name, "_nstrobe"}, 32'(obs_cnt - rd_idx), 32'd0);
    end else begin
      chk({name, "_nstrobe"}, 32'(obs_cnt - rd_idx), 32'd1);
      if (obs_cnt > rd_idx) chk({name, "_strobe"}, {16'd0, obs_arr[rd_idx]}, {16'd0, exp});
    end
    rd_idx = obs_cnt;
  endtask

  task automatic start_txn(input string name, input logic w, input logic r,
                           input logic [19:0] a, input logic [31:0] d);
    int n;
    static_wen = w; static_ren = r; static_addr = a; static_wdata = d;
    scan_id = 1'b1;
    n = 0;
    while (static_ready && n < 50) begin @(negedge clk); n++; end
    if (static_ready) begin
      checks++; failures++;
      $display("FAIL %s_accept static_ready stayed 1 for %0d cycles", name, n);
    end
    scan_id = 1'b0;
  endtask

  task automatic wait_resp(input string name, output int cyc);
    cyc = 0;
    while (!static_ready && cyc < 600) begin @(negedge clk); cyc++; end
    if (!static_ready) begin
      checks++; failures++;
      $display("FAIL %s_resp no static_ready within %0d cycles", name, cyc);
    end
    if (exp_q.size() > 0) chk({name, "_rdata"}, static_rdata, exp_q.pop_front());
  endtask

  task automatic run_txn(input string name, input logic w, input logic r, input logic [19:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input logic [15:0] exp_st, input int exp_cyc);
    int cyc;
    exp_q.push_back(exp_rd);
    start_txn(name, w, r, a, d);
    wait_resp(name, cyc);
    if (exp_cyc > 0) chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check_strobes(name, exp_st);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic        wen;
    logic        ren;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_strobe;
  } vec_t;

  function automatic vec_t mkv(input logic w, input logic r, input logic [19:0] a,
                               input logic [31:0] d, input logic [31:0] e, input logic [15:0] s);
    vec_t v;
    v.wen = w; v.ren = r; v.addr = a; v.wdata = d; v.exp_rdata = e; v.exp_strobe = s;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    int cyc;
    int n;
    int exp_cyc;
    rst = 1'b1; scan_id = 1'b0; fft_done = 1'b0;
    static_wen = 1'b0; static_ren = 1'b0; static_addr = '0; static_wdata = '0;

    vecs.push_back(mkv(1, 0, mk(0, 1, 9'h005), 32'h1234_5678, 32'h0,         sc(0, 1, 1, 9'h005)));
    vecs.push_back(mkv(0, 1, mk(0, 1, 9'h005), 32'h0,         32'h1234_5678, sc(0, 0, 1, 9'h005)));
    vecs.push_back(mkv(1, 0, mk(0, 0, 9'h000), 32'h0000_0AAA, 32'h0,         sc(0, 1, 0, 9'h000)));
    vecs.push_back(mkv(1, 0, mk(0, 0, 9'h001), 32'h0000_0BBB, 32'h0,         sc(0, 1, 0, 9'h001)));
    vecs.push_back(mkv(1, 0, mk(0, 0, 9'h002), 32'h0000_0CCC, 32'h0,         sc(0, 1, 0, 9'h002)));
    vecs.push_back(mkv(1, 0, mk(0, 0, 9'h1FF), 32'h5A5A_5A5A, 32'h0,         sc(0, 1, 0, 9'h1FF)));
    vecs.push_back(mkv(0, 1, mk(0, 0, 9'h1FF), 32'h0,         32'h5A5A_5A5A, sc(0, 0, 0, 9'h1FF)));
    vecs.push_back(mkv(0, 1, mk(1, 5, 9'h077), 32'h0,         32'h0000_0AAA, sc(0, 0, 0, 9'h000)));
    vecs.push_back(mkv(0, 1, mk(1, 0, 9'h000), 32'h0,         32'h0000_0BBB, sc(0, 0, 0, 9'h001)));
    vecs.push_back(mkv(0, 1, mk(1, 0, 9'h000), 32'h0,         32'h0000_0CCC, sc(0, 0, 0, 9'h002)));
    vecs.push_back(mkv(1, 0, mk(0, 7, 9'h000), 32'hCAFE_0000, 32'h0,         sc(1, 1, 0, 9'h000)));
    vecs.push_back(mkv(0, 1, mk(0, 7, 9'h000), 32'h0,         32'hCAFE_0000, sc(1, 0, 0, 9'h000)));
    vecs.push_back(mkv(0, 1, mk(0, 5, 9'h010), 32'h0,         32'hDEAD_BEEF, NONE));
    vecs.push_back(mkv(1, 1, mk(0, 0, 9'h003), 32'h0,         32'hDEAD_BEEF, NONE));
    vecs.push_back(mkv(0, 1, mk(0, 7, 9'h00F), 32'h0,         32'h0000_0003, NONE));
    vecs.push_back(mkv(1, 0, mk(0, 7, 9'h00F), 32'h1,         32'h0,         NONE));
    vecs.push_back(mkv(0, 1, mk(0, 7, 9'h00F), 32'h0,         32'h0000_0001, NONE));
    vecs.push_back(mkv(0, 1, mk(1, 0, 9'h000), 32'h0,         32'hCAFE_0000, sc(1, 0, 0, 9'h000)));
    vecs.push_back(mkv(0, 0, mk(0, 1, 9'h005), 32'h0,         32'hDEAD_BEEF, NONE));
    vecs.push_back(mkv(0, 1, mk(0, 7, 9'h00F), 32'h0,         32'h0000_0003, NONE));

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, static_ready}, 32'd1);
    chk("rst_rdata", static_rdata, 32'd0);
    chk("rst_strobes", {26'd0, sram_ren, sram_wen, reg_ren, reg_wen}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // table-driven vectors
    fft_done = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      sram_lat = i % 4;
      reg_lat  = $urandom_range(0, 3);
      if (vecs[i].exp_strobe == NONE) exp_cyc = 1;
      else if (vecs[i].exp_strobe[13]) exp_cyc = reg_lat + 2;
      else exp_cyc = sram_lat + 2;
      run_txn($sformatf("vec%0d", i), vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_strobe, exp_cyc);
    end

    // register target never answers -> timeout
    fft_done = 1'b0;
    run_txn("clr0", 1, 0, mk(0, 7, 9'h00F), 32'h1, 32'h0, NONE, 1);
    hold_reg_low = 1'b1;
    run_txn("timeout", 0, 1, mk(0, 7, 9'h002), 32'h0, 32'hDEAD_BEEF, sc(1, 0, 0, 9'h002), 257);
    hold_reg_low = 1'b0;
    run_txn("sts_to", 0, 1, mk(0, 7, 9'h00F), 32'h0, 32'h0000_0004, NONE, 1);
    run_txn("clr1", 1, 0, mk(0, 7, 9'h00F), 32'h1, 32'h0, NONE, 1);

    // second request while the first is waiting on a slow bank
    sram_lat = 20;
    exp_q.push_back(32'h1234_5678);
    start_txn("ovr", 0, 1, mk(0, 1, 9'h005), 32'h0);
    repeat (4) @(negedge clk);
    static_addr = mk(0, 0, 9'h001);
    scan_id = 1'b1;
    repeat (5) @(negedge clk);
    scan_id = 1'b0;
    wait_resp("ovr", cyc);
    check_strobes("ovr", sc(0, 0, 1, 9'h005));
    repeat (8) @(negedge clk);
    chk("ovr_hold_rdata", static_rdata, 32'h1234_5678);
    chk("ovr_hold_ready", {31'd0, static_ready}, 32'd1);
    check_strobes("ovr_quiet", NONE);
    sram_lat = 1;
    run_txn("sts_ovr", 0, 1, mk(0, 7, 9'h00F), 32'h0, 32'h0000_0008, NONE, 1);

    // reset while the strobe is out
    sram_lat = 5;
    start_txn("rst_mid", 1, 0, mk(0, 0, 9'h00A), 32'h7777_7777);
    n = 0;
    while (!(|sram_wen) && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_strobe_seen", {31'd0, |sram_wen}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {26'd0, sram_ren, sram_wen, reg_ren, reg_wen}, 32'd0);
    chk("rst_mid_ready", {31'd0, static_ready}, 32'd1);
    chk("rst_mid_state", {29'd0, state_dbg}, {29'd0, IDLE});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_strobes("rst_mid", sc(0, 1, 0, 9'h00A));
    chk("rst_mid_ready_after", {31'd0, static_ready}, 32'd1);
    chk("rst_mid_rdata_after", static_rdata, 32'd0);
    run_txn("sts_after_rst", 0, 1, mk(0, 7, 9'h00F), 32'h0, 32'h0, NONE, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
